// File: rtl/bcd_count_scan_if.sv
// Bundle of the counter's control inputs and display-side outputs.
//   master : drives en/up/load/load_val/clr_ovf, observes count/ovf/digit/an_n
//   slave  : the counter itself
interface bcd_count_scan_if;
  logic        en;        // counting enable, gates the prescaler
  logic        up;        // 1 = increment, 0 = decrement
  logic        load;      // one-cycle load strobe
  logic [15:0] load_val;  // four BCD digits, [3:0] least significant
  logic        clr_ovf;   // clears sticky overflow
  logic [15:0] count;     // registered BCD count
  logic        ovf;       // sticky wrap flag
  logic [3:0]  digit;     // code of the selected digit, to the 7-seg decoder
  logic [3:0]  an_n;      // active-low one-cold digit select

  modport master (
    output en, up, load, load_val, clr_ovf,
    input  count, ovf, digit, an_n
  );

  modport slave (
    input  en, up, load, load_val, clr_ovf,
    output count, ovf, digit, an_n
  );
endinterface

// File: rtl/bcd_count_scan.sv
// Four-digit BCD up/down counter with tick prescaler and digit-scan mux.
// Feeds one shared hex-to-7-seg decoder for a multiplexed 4-digit display.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : control inputs (en, up, load, load_val, clr_ovf) and outputs
//           (count, ovf, digit, an_n); see bcd_count_scan_if.
// While ovf is set every scanned digit shows 4'hF (rendered as "-").

// Per-digit BCD step and load clamp. sat flags that this digit would
// carry (9 going up) or borrow (0 going down) if stepped, so the top can
// form all carry-ins in parallel rather than rippling through cells.
module bcd_digit_cell (
  input  logic [3:0] cur,
  input  logic [3:0] raw,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] nxt,
  output logic [3:0] clamped,
  output logic       sat
);
  always_comb begin
    clamped = (raw > 4'd9) ? 4'd9 : raw;
    sat     = up ? (cur >= 4'd9) : (cur == 4'd0);
    nxt     = cur;
    if (cin) begin
      if (up) nxt = (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
      else    nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
    end
  end
endmodule

module bcd_count_scan #(
  parameter int PRESCALE = 1000,
  parameter int SCAN_DIV = 250
) (
  input logic             clk,
  input logic             rst_n,
  bcd_count_scan_if.slave bus
);
  localparam int NUM_DIGITS = 4;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef struct packed {
    logic [3:0] digit;
    logic [3:0] an_n;
  } disp_t;

  logic [PW-1:0]                 pcnt;
  logic [SW-1:0]                 scnt;
  logic [1:0]                    idx;
  logic [NUM_DIGITS-1:0][3:0]    count_q;
  logic [NUM_DIGITS-1:0][3:0]    count_nxt;
  logic [NUM_DIGITS-1:0][3:0]    load_clamped;
  logic [NUM_DIGITS-1:0]         sat;
  logic [NUM_DIGITS-1:0]         cin;
  logic                          ovf_q;
  logic                          tick;
  logic                          wrap;
  logic                          scan_wrap;
  disp_t                         disp_q;
  disp_t                         disp_nxt;

  assign tick      = bus.en && (pcnt == PW'(PRESCALE - 1));
  assign scan_wrap = (scnt == SW'(SCAN_DIV - 1));

  // Digit i steps when every lower digit is saturated; digit 0 always steps.
  always_comb begin
    cin[0] = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) cin[i] = cin[i-1] & sat[i-1];
  end
  assign wrap = &sat;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_cell u_cell (
      .cur     (count_q[g]),
      .raw     (bus.load_val[4*g +: 4]),
      .up      (bus.up),
      .cin     (cin[g]),
      .nxt     (count_nxt[g]),
      .clamped (load_clamped[g]),
      .sat     (sat[g])
    );
  end

  // Prescaler: load restarts the tick period; en=0 freezes it in place.
  always_ff @(posedge clk) begin
    if (!rst_n)       pcnt <= '0;
    else if (bus.load) pcnt <= '0;
    else if (bus.en)   pcnt <= tick ? '0 : pcnt + PW'(1);
  end

  // Count and sticky flag. A load swallows a coincident tick, so no wrap
  // can fire then; a wrap beats clr_ovf in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (bus.load)  count_q <= load_clamped;
      else if (tick) count_q <= count_nxt;
      if (tick && wrap && !bus.load) ovf_q <= 1'b1;
      else if (bus.clr_ovf)          ovf_q <= 1'b0;
    end
  end

  // Scan divider runs independently of en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scnt <= '0;
      idx  <= 2'd0;
    end else if (scan_wrap) begin
      scnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      scnt <= scnt + SW'(1);
    end
  end

  always_comb begin
    disp_nxt.an_n  = ~(4'b0001 << idx);
    disp_nxt.digit = ovf_q ? 4'hF : count_q[idx];
  end

  // Output register: one cycle behind idx/count/ovf; all digits off in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q.digit <= 4'h0;
      disp_q.an_n  <= 4'b1111;
    end else begin
      disp_q <= disp_nxt;
    end
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.digit = disp_q.digit;
  assign bus.an_n  = disp_q.an_n;
endmodule

// File: tb/tb_bcd_count_scan.sv
module tb_bcd_count_scan;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  bcd_count_scan_if bus ();

  bcd_count_scan #(.PRESCALE(4), .SCAN_DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1 ns after.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle stimulus (load/up/clr_ovf), then wait cycles, then check.
  typedef struct {
    string       name;
    logic        load;
    logic [15:0] load_val;
    logic        up;
    logic        clr;
    int          wait_cyc;
    logic [15:0] exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"wrap_up",      1'b1, 16'h9999, 1'b1, 1'b0, 4, 16'h0000, 1'b1};
    vecs[1] = '{"wrap_down",    1'b1, 16'h0000, 1'b0, 1'b1, 4, 16'h9999, 1'b1};
    vecs[2] = '{"no_tick_yet",  1'b1, 16'h0123, 1'b1, 1'b1, 3, 16'h0123, 1'b0};
    vecs[3] = '{"carry_mid",    1'b1, 16'h0129, 1'b1, 1'b0, 4, 16'h0130, 1'b0};
    vecs[4] = '{"borrow_chain", 1'b1, 16'h1000, 1'b0, 1'b0, 4, 16'h0999, 1'b0};
    vecs[5] = '{"clamp_load",   1'b1, 16'h3A7F, 1'b1, 1'b0, 0, 16'h3979, 1'b0};
    vecs[6] = '{"clamp_wrap",   1'b1, 16'hFFFF, 1'b1, 1'b0, 4, 16'h0000, 1'b1};
    vecs[7] = '{"load_keeps_ovf", 1'b1, 16'h0990, 1'b1, 1'b0, 4, 16'h0991, 1'b1};

    rst_n = 1'b0;
    bus.en = 1'b1; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = 16'h0; bus.clr_ovf = 1'b0;
    step(2);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_ovf",   32'(bus.ovf),   32'h0);
    chk("rst_digit", 32'(bus.digit), 32'h0);
    chk("rst_an_n",  32'(bus.an_n),  32'hF);

    // Count up from reset and check the scan pattern.
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int sidx;
      logic [3:0] exp_an;
      step(1);
      sidx = ((k - 1) / 2) % 4;
      exp_an = ~(4'b0001 << sidx);
      chk($sformatf("scan_an_n_%0d", k), 32'(bus.an_n), 32'(exp_an));
      chk($sformatf("scan_digit_%0d", k), 32'(bus.digit),
          (sidx == 0) ? 32'((k - 1) / 4) : 32'h0);
      if (k % 4 == 0) chk($sformatf("up_count_%0d", k), 32'(bus.count), 32'(k / 4));
    end

    // Table-driven vectors.
    for (int v = 0; v < 8; v++) begin
      bus.load = vecs[v].load; bus.load_val = vecs[v].load_val;
      bus.up = vecs[v].up; bus.clr_ovf = vecs[v].clr;
      step(1);
      bus.load = 1'b0; bus.clr_ovf = 1'b0;
      step(vecs[v].wait_cyc);
      chk({vecs[v].name, "_count"}, 32'(bus.count), 32'(vecs[v].exp_count));
      chk({vecs[v].name, "_ovf"},   32'(bus.ovf),   32'(vecs[v].exp_ovf));
    end

    // Wrap up then every scanned digit shows F.
    bus.load = 1'b1; bus.load_val = 16'h9999; bus.up = 1'b1; bus.clr_ovf = 1'b1;
    step(1);
    bus.load = 1'b0; bus.clr_ovf = 1'b0;
    step(4);
    chk("seq_wrap_up_count", 32'(bus.count), 32'h0);
    chk("seq_wrap_up_ovf",   32'(bus.ovf),   32'h1);
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk($sformatf("dash_digit_%0d", k), 32'(bus.digit), 32'hF);
    end

    // Wrap down, freeze, clear ovf, then all positions show 9.
    bus.load = 1'b1; bus.load_val = 16'h0000; bus.up = 1'b0;
    step(1);
    bus.load = 1'b0;
    step(4);
    bus.en = 1'b0;
    chk("seq_wrap_dn_count", 32'(bus.count), 32'h9999);
    chk("seq_wrap_dn_ovf",   32'(bus.ovf),   32'h1);
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    chk("clr_ovf", 32'(bus.ovf), 32'h0);
    step(1);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] a;
      step(1);
      a = bus.an_n;
      chk($sformatf("nine_digit_%0d", k), 32'(bus.digit), 32'h9);
      chk($sformatf("one_cold_%0d", k), 32'($countones(~a)), 32'h1);
    end

    // Load on the tick cycle: tick discarded, next tick PRESCALE later.
    bus.en = 1'b1; bus.up = 1'b1;
    bus.load = 1'b1; bus.load_val = 16'h0000;
    step(1);
    bus.load = 1'b0;
    step(3);
    bus.load = 1'b1; bus.load_val = 16'h3A7F;
    step(1);
    bus.load = 1'b0;
    chk("prio_load", 32'(bus.count), 32'h3979);
    step(3);
    chk("prio_hold", 32'(bus.count), 32'h3979);
    step(1);
    chk("prio_next_tick", 32'(bus.count), 32'h3980);

    // clr_ovf coinciding with a wrap: set wins.
    bus.load = 1'b1; bus.load_val = 16'h9999; bus.clr_ovf = 1'b1;
    step(1);
    bus.load = 1'b0; bus.clr_ovf = 1'b0;
    chk("sim_pre_ovf", 32'(bus.ovf), 32'h0);
    step(3);
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    chk("sim_count", 32'(bus.count), 32'h0);
    chk("sim_ovf",   32'(bus.ovf),   32'h1);

    // Enable gating: freeze mid-prescale, resume without restart.
    bus.load = 1'b1; bus.load_val = 16'h0500;
    step(1);
    bus.load = 1'b0;
    step(2);
    bus.en = 1'b0;
    step(10);
    chk("gate_hold", 32'(bus.count), 32'h0500);
    bus.en = 1'b1;
    step(1);
    chk("gate_resume_pre", 32'(bus.count), 32'h0500);
    step(1);
    chk("gate_resume_tick", 32'(bus.count), 32'h0501);

    // Mid-run reset.
    rst_n = 1'b0;
    step(1);
    chk("mrst_count", 32'(bus.count), 32'h0);
    chk("mrst_ovf",   32'(bus.ovf),   32'h0);
    chk("mrst_digit", 32'(bus.digit), 32'h0);
    chk("mrst_an_n",  32'(bus.an_n),  32'hF);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_an_n",  32'(bus.an_n),  32'hE);
    chk("post_rst_digit", 32'(bus.digit), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_count_scan.md
# bcd_count_scan

Four-digit BCD up/down counter with a built-in tick prescaler and digit-scan multiplexer. It is the stage directly upstream of the hex-to-seven-segment decoder. Each cycle it presents one 4-bit digit code on `digit`, which feeds the decoder's 4-bit input, plus the matching active-low digit enable on `an_n`, so one shared decoder drives a multiplexed 4-digit display. An overflow or underflow latches a sticky flag, and while the flag is set every digit shows code 4'hF, which the decoder renders as "-".

## Interface
- `PRESCALE`, default 1000: clock cycles per count tick, ≥1.
- `SCAN_DIV`, default 250: clock cycles each digit stays selected, ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: counting enable; gates the prescaler.
- `up`  in  1: count direction; 1 = increment, 0 = decrement; sampled on the tick cycle.
- `load`  in  1: one-cycle strobe; loads `load_val` into the count.
- `load_val`  in  16: four BCD digits, [3:0] = least significant.
- `clr_ovf`  in  1: clears the sticky `ovf` flag.
- `count`  out  16: current BCD count, registered.
- `ovf`  out  1: sticky wrap flag.
- `digit`  out  4: code for the currently selected digit, to the decoder input.
- `an_n`  out  4: active-low digit select, one-cold; bit i = digit i.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 while `en`=1, wraps to 0, and holds while `en`=0. A tick occurs on the cycle where `en`=1 and `pcnt`==PRESCALE-1.
- On a tick the count goes up or down by 1 in BCD. Each digit rolls 9→0 with carry, or 0→9 with borrow.
- Wrap at the ends:
  - Counting up from 9999 gives 0000 and sets `ovf`.
  - Counting down from 0000 gives 9999 and sets `ovf`.
- Load behaviour:
  - `load` has priority over a tick in the same cycle; that tick is discarded.
  - `load` clears `pcnt` to 0.
  - `load` does not change `ovf`.
- Any `load_val` nibble above 9 is clamped to 9. Example: 16'h3A7F loads as 16'h3979.
- `clr_ovf` clears `ovf`. If a wrap happens in the same cycle, the set wins and `ovf` stays 1.
- Scan:
  - Counter `scnt` counts 0..SCAN_DIV-1 regardless of `en`.
  - When it wraps, index `idx` advances 0→1→2→3→0.
  - `idx` 0 selects the least significant digit.
- Registered output stage, updated every cycle:
  - `an_n` ← one-cold pattern for `idx` (idx 0 gives 4'b1110).
  - `digit` ← 4'hF if `ovf` is set, otherwise nibble `idx` of `count`.
  - `digit` never carries 4'hA..4'hE.
- Reset (`rst_n`=0 at a clock edge) values:
  - `count`=16'h0000, `ovf`=0, `pcnt`=0, `scnt`=0, `idx`=0.
  - `digit`=4'h0, `an_n`=4'b1111 (all digits off).
- Reset mid-count or mid-scan discards all state on that edge. No partial update survives.

## Timing
- `count` changes on the clock edge that samples a tick or `load`, so it is visible the next cycle.
- `ovf` sets on the same edge as the wrapping `count` update.
- Output latency:
  - `digit` and `an_n` lag `idx`, `count` and `ovf` by one cycle.
  - The first cycle after reset is released shows `an_n`=4'b1110 and `digit`=4'h0.
- Scan timing:
  - Each digit is held for exactly SCAN_DIV cycles.
  - A full frame is 4×SCAN_DIV cycles.
  - `an_n` never has more than one low bit.
- With `en` held at 1, ticks are exactly PRESCALE cycles apart. The first tick comes PRESCALE cycles after reset release or after `load`.
- Deasserting `en` freezes `pcnt`. Reasserting it resumes from the frozen value; there is no restart.

## Test plan
- Reset, then count up, with PRESCALE=4, SCAN_DIV=2:
  - Release `rst_n` with `en`=1 and `up`=1.
  - Required: `count` reads 0001, 0002, 0003 after 4, 8 and 12 cycles.
  - Required: `an_n` cycles 1110, 1101, 1011, 0111, each held for 2 cycles.
- Wrap up:
  - Load 16'h9999, `up`=1, wait one tick.
  - Required: `count`=16'h0000 and `ovf`=1.
  - Required: from the next cycle onward, every `digit`=4'hF.
- Wrap down:
  - Load 16'h0000, `up`=0, wait one tick.
  - Required: `count`=16'h9999 and `ovf`=1.
  - Then pulse `clr_ovf`. Required: `ovf`=0 and `digit` shows 9 on every scan position.
- Load clamp and priority:
  - Pulse `load` with `load_val`=16'h3A7F on the tick cycle.
  - Required: `count`=16'h3979, the tick is ignored, and the next tick comes PRESCALE cycles later, giving 16'h3980.
- Simultaneous clear and wrap:
  - Assert `clr_ovf` on the cycle where 9999 wraps up.
  - Required: `ovf`=1 afterwards.
- Enable gating and mid-run reset:
  - Drop `en` for 10 cycles mid-prescale. Required: no tick, and `count` holds.
  - Assert `rst_n`=0 for 1 cycle. Required: every output returns to its reset value, including `an_n`=4'b1111.
